// File: rtl/nonce_scheduler.sv
// Nonce sweep sequencer: issues NUM_CORES nonces per cycle to the hashing cores,
// buffers their hit reports per core and drains them round-robin into one write port.

module nonce_hold #(
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic               hit,
  input  logic [NONCE_W-1:0] hit_nonce,
  input  logic               grant,
  output logic               occupied,
  output logic [NONCE_W-1:0] nonce,
  output logic               drop
);

  // A hit landing on the cycle this entry is granted refills it instead of dropping.
  assign drop = accept && hit && occupied && !grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      occupied <= 1'b0;
      nonce    <= '0;
    end else if (accept && hit && (!occupied || grant)) begin
      occupied <= 1'b1;
      nonce    <= hit_nonce;
    end else if (grant) begin
      occupied <= 1'b0;
    end
  end

endmodule

module nonce_scheduler #(
  parameter int NUM_CORES = 3,
  parameter int COUNTBITS = 6,
  parameter int DELAY_C   = 129,
  parameter int NONCE_W   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           issue_valid,
  output logic [NUM_CORES*NONCE_W-1:0]   issue_nonce,
  input  logic [NUM_CORES-1:0]           hit_valid,
  input  logic [NUM_CORES*NONCE_W-1:0]   hit_nonce,
  output logic                           wr_en,
  output logic [NONCE_W-1:0]             wr_nonce,
  input  logic                           wr_full,
  output logic                           overflow
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int DW = $clog2(DELAY_C + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                             state;
  logic [COUNTBITS-1:0]               count;
  logic [NONCE_W-1:0]                 base;
  logic [DW-1:0]                      drain_cnt;
  logic [PW-1:0]                      ptr;

  logic [NUM_CORES-1:0]               occ;
  logic [NUM_CORES-1:0]               drop;
  logic [NUM_CORES-1:0]               grant;
  logic [NUM_CORES-1:0][NONCE_W-1:0]  hold_nonce;
  logic [NUM_CORES-1:0][NONCE_W-1:0]  hit_lane;

  logic                               accept;
  logic                               any_occ;
  logic                               can_grant;
  logic                               start_ok;
  logic                               found;
  logic [PW-1:0]                      gnt_idx;
  logic [PW-1:0]                      ptr_next;

  assign hit_lane  = hit_nonce;
  assign accept    = (state != IDLE);
  assign any_occ   = |occ;
  assign can_grant = !wr_full && any_occ;
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign ptr_next  = (gnt_idx == PW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;

  // Round-robin search: first occupied hold at or above ptr, wrapping.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    idx_p   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      idx_p = PW'(idx);
      if (!found && occ[idx_p]) begin
        found   = 1'b1;
        gnt_idx = idx_p;
      end
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    assign grant[i] = can_grant && (gnt_idx == PW'(i));

    nonce_hold #(.NONCE_W(NONCE_W)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept),
      .hit       (hit_valid[i]),
      .hit_nonce (hit_lane[i]),
      .grant     (grant[i]),
      .occupied  (occ[i]),
      .nonce     (hold_nonce[i]),
      .drop      (drop[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      base        <= '0;
      drain_cnt   <= '0;
      ptr         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      issue_valid <= 1'b0;
      issue_nonce <= '0;
      wr_en       <= 1'b0;
      wr_nonce    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_en <= can_grant;
      if (can_grant) begin
        wr_nonce <= hold_nonce[gnt_idx];
        ptr      <= ptr_next;
      end

      // A drop in the same cycle as a restart still gets reported.
      if (start_ok) overflow <= 1'b0;
      if (|drop)    overflow <= 1'b1;

      issue_valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
            count <= '0;
            base  <= '0;
          end
        end
        RUN: begin
          if (!any_occ) begin
            issue_valid <= 1'b1;
            for (int i = 0; i < NUM_CORES; i++)
              issue_nonce[i*NONCE_W +: NONCE_W] <= base + NONCE_W'(i);
            base  <= base + NONCE_W'(NUM_CORES);
            count <= count + 1'b1;
            if (&count) begin
              state     <= DRAIN;
              drain_cnt <= DW'(DELAY_C);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0 && !any_occ && hit_valid == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: sweep timing, round-robin write drain,
// backpressure/overflow, restart and mid-run reset.

module tb_nonce_scheduler;

  localparam int NC = 3;
  localparam int NW = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              issue_valid;
  logic [NC*NW-1:0]  issue_nonce;
  logic [NC-1:0]     hit_valid;
  logic [NC*NW-1:0]  hit_nonce;
  logic              wr_en;
  logic [NW-1:0]     wr_nonce;
  logic              wr_full;
  logic              overflow;

  int passed = 0;
  int total  = 0;

  nonce_scheduler #(.NUM_CORES(NC), .COUNTBITS(6), .DELAY_C(129), .NONCE_W(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .issue_valid (issue_valid),
    .issue_nonce (issue_nonce),
    .hit_valid   (hit_valid),
    .hit_nonce   (hit_nonce),
    .wr_en       (wr_en),
    .wr_nonce    (wr_nonce),
    .wr_full     (wr_full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  mask;
    logic [31:0] n0, n1, n2;
    int          nw;
    logic [31:0] w0, w1, w2;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int          n;
    int          bad;
    logic [31:0] expw;

    // Pointer walk: 0 -> 2 -> 1 -> 1 -> 1 -> 0 -> 0
    tbl[0] = '{3'b010, 32'h0,  32'h11, 32'h0,  1, 32'h11, 32'h0,  32'h0};
    tbl[1] = '{3'b101, 32'h20, 32'h0,  32'h22, 2, 32'h22, 32'h20, 32'h0};
    tbl[2] = '{3'b101, 32'h30, 32'h0,  32'h32, 2, 32'h32, 32'h30, 32'h0};
    tbl[3] = '{3'b111, 32'h40, 32'h41, 32'h42, 3, 32'h41, 32'h42, 32'h40};
    tbl[4] = '{3'b100, 32'h0,  32'h0,  32'h52, 1, 32'h52, 32'h0,  32'h0};
    tbl[5] = '{3'b111, 32'h60, 32'h61, 32'h62, 3, 32'h60, 32'h61, 32'h62};

    rst = 1'b1; start = 1'b0; hit_valid = '0; hit_nonce = '0; wr_full = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_iv", issue_valid, 0);
    check("rst_inonce", issue_nonce, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_nonce", wr_nonce, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Clean sweep with a stray start pulse mid-run
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("sweep_busy", busy, 1);
    check("sweep_iv_pre", issue_valid, 0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check($sformatf("sweep_iv%0d", k), issue_valid, 1);
      check($sformatf("sweep_n0_%0d", k), issue_nonce[0*NW +: NW], 64'(3*k));
      check($sformatf("sweep_n1_%0d", k), issue_nonce[1*NW +: NW], 64'(3*k+1));
      check($sformatf("sweep_n2_%0d", k), issue_nonce[2*NW +: NW], 64'(3*k+2));
      start = (k == 20);
    end
    start = 1'b0;
    check("sweep_busy_last", busy, 1);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", 64'(n), 130);
    check("done_busy", busy, 0);
    check("done_iv", issue_valid, 0);

    // Round-robin table, applied in DONE where hits are still accepted
    for (int r = 0; r < 6; r++) begin
      hit_valid = tbl[r].mask;
      hit_nonce = {tbl[r].n2, tbl[r].n1, tbl[r].n0};
      @(negedge clk);
      hit_valid = '0;
      check($sformatf("tbl%0d_capture_wr", r), wr_en, 0);
      for (int k = 0; k < tbl[r].nw; k++) begin
        @(negedge clk);
        expw = (k == 0) ? tbl[r].w0 : (k == 1) ? tbl[r].w1 : tbl[r].w2;
        check($sformatf("tbl%0d_wr_en%0d", r, k), wr_en, 1);
        check($sformatf("tbl%0d_wr_nonce%0d", r, k), wr_nonce, expw);
      end
      @(negedge clk);
      check($sformatf("tbl%0d_idle_wr", r), wr_en, 0);
      check($sformatf("tbl%0d_ovf", r), overflow, 0);
    end

    // Backpressure: hold 1 stuck behind wr_full, second hit overflows
    wr_full = 1'b1;
    hit_valid = 3'b010; hit_nonce = {32'h0, 32'hAA, 32'h0};
    @(negedge clk);
    hit_valid = '0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr_en !== 1'b0) bad++;
      if (c == 4) begin hit_valid = 3'b010; hit_nonce = {32'h0, 32'hBB, 32'h0}; end
      if (c == 5) begin hit_valid = '0; check("bp_ovf_set", overflow, 1); end
    end
    check("bp_no_wr", 64'(bad), 0);
    wr_full = 1'b0;
    @(negedge clk);
    check("bp_wr_en", wr_en, 1);
    check("bp_wr_nonce", wr_nonce, 32'hAA);
    check("bp_ovf_sticky", overflow, 1);
    @(negedge clk);
    check("bp_wr_once", wr_en, 0);
    check("bp_done_hold", done, 1);

    // Restart from DONE
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("re_done", done, 0);
    check("re_ovf", overflow, 0);
    check("re_busy", busy, 1);
    @(negedge clk);
    check("re_iv", issue_valid, 1);
    check("re_n0", issue_nonce[0*NW +: NW], 0);
    check("re_n1", issue_nonce[1*NW +: NW], 1);
    check("re_n2", issue_nonce[2*NW +: NW], 2);

    // Hit on core 2 in RUN moves the pointer from 2 back to 0, stalling one cycle
    hit_valid = 3'b100; hit_nonce = {32'h55, 32'h0, 32'h0};
    @(negedge clk); hit_valid = '0;
    check("run_h_iv", issue_valid, 1);
    check("run_h_n0", issue_nonce[0*NW +: NW], 3);
    @(negedge clk);
    check("run_h_wr_en", wr_en, 1);
    check("run_h_wr_nonce", wr_nonce, 32'h55);
    check("run_h_stall", issue_valid, 0);
    @(negedge clk);
    check("run_h_resume", issue_valid, 1);
    check("run_h_resume_n0", issue_nonce[0*NW +: NW], 6);

    // Simultaneous hits 7/8/9 with pointer 0
    hit_valid = 3'b111; hit_nonce = {32'd9, 32'd8, 32'd7};
    @(negedge clk); hit_valid = '0;
    check("sim_iv_capture", issue_valid, 1);
    check("sim_n0_capture", issue_nonce[0*NW +: NW], 9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("sim_wr_en%0d", k), wr_en, 1);
      check($sformatf("sim_wr_nonce%0d", k), wr_nonce, 64'(7 + k));
      check($sformatf("sim_stall%0d", k), issue_valid, 0);
    end
    @(negedge clk);
    check("sim_resume_iv", issue_valid, 1);
    check("sim_resume_n0", issue_nonce[0*NW +: NW], 12);
    check("sim_resume_wr", wr_en, 0);

    // Reset mid-RUN for two cycles
    rst = 1'b1;
    @(negedge clk);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_iv", issue_valid, 0);
    check("mr_inonce", issue_nonce, 0);
    check("mr_wr_en", wr_en, 0);
    check("mr_wr_nonce", wr_nonce, 0);
    check("mr_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    hit_valid = 3'b111; hit_nonce = {32'h3, 32'h2, 32'h1};
    @(negedge clk); hit_valid = '0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || overflow !== 1'b0) bad++;
    end
    check("idle_hits_ignored", 64'(bad), 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("mr_restart_busy", busy, 1);
    @(negedge clk);
    check("mr_restart_iv", issue_valid, 1);
    check("mr_restart_n0", issue_nonce[0*NW +: NW], 0);
    check("mr_restart_n2", issue_nonce[2*NW +: NW], 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
